// File: rtl/decode_hzd_ctrl.sv
// decode_hzd_ctrl
// Issue controller and register scoreboard that sits between fetch and decode.
// It accepts instructions from fetch over a valid/ready handshake. It keeps one
// pending bit per architectural register whose write is still in flight. Any
// instruction whose sources or destination are pending is held. Issued
// instructions go into a single registered slot with a valid/ready handshake
// toward execute.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   if_vld, if_inst     fetch offer
//   if_rdy              controller accepts if_inst this cycle
//   ex_vld, ex_inst     issue slot toward decode/execute
//   ex_rdy              execute consumes the slot this cycle
//   wb_rgf_we/wa        write-back port, clears scoreboard entries
//   flush               drop slot content and the current fetch offer
//   hzd_stall           valid fetch instruction blocked by the scoreboard
//   sb_pend             scoreboard, bit n = write to xn pending (bit 0 always 0)
//   stall_cnt           saturating count of hazard-stall cycles
module decode_hzd_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_vld,
  input  logic [31:0]      if_inst,
  output logic             if_rdy,
  output logic             ex_vld,
  output logic [31:0]      ex_inst,
  input  logic             ex_rdy,
  input  logic             wb_rgf_we,
  input  logic [4:0]       wb_rgf_wa,
  input  logic             flush,
  output logic             hzd_stall,
  output logic [31:0]      sb_pend,
  output logic [CNT_W-1:0] stall_cnt
);

  // Opcode constants, matching the utils_top encodings (RV32I major opcodes).
  localparam logic [6:0] OP_RR     = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_HAZ  = 2'd1,
    S_FLSH = 2'd2
  } state_t;

  // Saturating increment: hold at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t           r_state;
  logic             r_ex_vld;
  logic [31:0]      r_ex_inst;
  logic [31:0]      r_pend;
  logic [CNT_W-1:0] r_stall_cnt;

  logic [4:0]  w_rs1, w_rs2, w_rd;
  logic        w_use_rs1, w_use_rs2, w_wr_rd;
  logic        w_hazard, w_slot_free, w_bubble, w_if_rdy, w_issue, w_hzd_stall;
  logic [31:0] w_pend_nxt;

  assign w_rs1 = if_inst[19:15];
  assign w_rs2 = if_inst[24:20];
  assign w_rd  = if_inst[11:7];

  // Operand usage by opcode class; unknown opcodes neither read nor write.
  always_comb begin
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_wr_rd   = 1'b0;
    case (if_inst[6:0])
      OP_RR:                        begin w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_wr_rd = 1'b1; end
      OP_STORE, OP_BRANCH:          begin w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
      OP_JALR, OP_LOAD, OP_OP_IMM:  begin w_use_rs1 = 1'b1; w_wr_rd = 1'b1; end
      OP_LUI, OP_AUIPC, OP_JAL:     w_wr_rd = 1'b1;
      default:                      ;
    endcase
  end

  // Hazard uses only the registered scoreboard: a write-back in this same
  // cycle is not bypassed. x0 is excluded explicitly for the sources; for the
  // destination it is covered because pend[0] is never set.
  assign w_hazard = (w_use_rs1 & (w_rs1 != 5'd0) & r_pend[w_rs1])
                  | (w_use_rs2 & (w_rs2 != 5'd0) & r_pend[w_rs2])
                  | (w_wr_rd   & r_pend[w_rd]);

  assign w_slot_free = ~r_ex_vld | ex_rdy;
  assign w_bubble    = (r_state == S_FLSH);
  assign w_if_rdy    = ~w_hazard & w_slot_free & ~flush & ~w_bubble;
  assign w_issue     = if_vld & w_if_rdy;
  assign w_hzd_stall = if_vld & w_hazard & ~flush;

  // Clear from write-back first, then set from issue so the set wins when
  // both target the same register.
  always_comb begin
    w_pend_nxt = r_pend;
    if (wb_rgf_we)
      w_pend_nxt[wb_rgf_wa] = 1'b0;
    if (w_issue && w_wr_rd && (w_rd != 5'd0))
      w_pend_nxt[w_rd] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_RUN;
      r_ex_vld    <= 1'b0;
      r_ex_inst   <= 32'd0;
      r_pend      <= 32'd0;
      r_stall_cnt <= '0;
    end else begin
      if (flush) begin
        r_state <= S_FLSH;
      end else begin
        case (r_state)
          S_RUN:   if (w_hzd_stall) r_state <= S_HAZ;
          S_HAZ:   if (w_issue) r_state <= S_RUN;
          S_FLSH:  r_state <= S_RUN;
          default: r_state <= S_RUN;
        endcase
      end

      if (w_issue) begin
        r_ex_vld  <= 1'b1;
        r_ex_inst <= if_inst;
      end else if (ex_rdy || flush) begin
        r_ex_vld  <= 1'b0;
      end

      r_pend <= w_pend_nxt;

      if (w_hzd_stall)
        r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

  assign if_rdy    = w_if_rdy;
  assign hzd_stall = w_hzd_stall;
  assign ex_vld    = r_ex_vld;
  assign ex_inst   = r_ex_inst;
  assign sb_pend   = r_pend;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_decode_hzd_ctrl.sv
module tb_decode_hzd_ctrl;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             if_vld;
  logic [31:0]      if_inst;
  logic             if_rdy;
  logic             ex_vld;
  logic [31:0]      ex_inst;
  logic             ex_rdy;
  logic             wb_rgf_we;
  logic [4:0]       wb_rgf_wa;
  logic             flush;
  logic             hzd_stall;
  logic [31:0]      sb_pend;
  logic [CNT_W-1:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  decode_hzd_ctrl #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_vld    (if_vld),
    .if_inst   (if_inst),
    .if_rdy    (if_rdy),
    .ex_vld    (ex_vld),
    .ex_inst   (ex_inst),
    .ex_rdy    (ex_rdy),
    .wb_rgf_we (wb_rgf_we),
    .wb_rgf_wa (wb_rgf_wa),
    .flush     (flush),
    .hzd_stall (hzd_stall),
    .sb_pend   (sb_pend),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; if_vld = 1'b0; if_inst = 32'd0; ex_rdy = 1'b0;
    wb_rgf_we = 1'b0; wb_rgf_wa = 5'd0; flush = 1'b0;
    #12;
    check("rst_ex_vld",  32'(ex_vld),    32'd0);
    check("rst_ex_inst", ex_inst,        32'd0);
    check("rst_sb_pend", sb_pend,        32'd0);
    check("rst_cnt",     32'(stall_cnt), 32'd0);
    rst_n = 1'b1;
    ex_rdy = 1'b1;
    #1;
    check("rst_if_rdy",  32'(if_rdy),    32'd1);
    check("rst_hzd",     32'(hzd_stall), 32'd0);
    tick();

    // addi x1,x0,5
    if_vld = 1'b1; if_inst = 32'h00500093;
    #1 check("addi_if_rdy", 32'(if_rdy), 32'd1);
    tick();
    check("addi_ex_vld",  32'(ex_vld), 32'd1);
    check("addi_ex_inst", ex_inst,     32'h00500093);
    check("addi_pend",    sb_pend,     32'h00000002);

    // add x2,x1,x1 stalls on x1
    if_inst = 32'h00108133;
    #1 check("raw_hzd",    32'(hzd_stall), 32'd1);
    check("raw_if_rdy",    32'(if_rdy),    32'd0);
    tick();
    check("raw_cnt1", 32'(stall_cnt), 32'd1);
    tick();
    check("raw_cnt2", 32'(stall_cnt), 32'd2);
    // write-back of x1 in this cycle is not bypassed
    wb_rgf_we = 1'b1; wb_rgf_wa = 5'd1;
    #1 check("raw_nobyp_hzd", 32'(hzd_stall), 32'd1);
    check("raw_nobyp_rdy",    32'(if_rdy),    32'd0);
    tick();
    wb_rgf_we = 1'b0;
    #1 check("raw_rel_rdy", 32'(if_rdy),    32'd1);
    check("raw_rel_hzd",    32'(hzd_stall), 32'd0);
    tick();
    check("raw_pend",    sb_pend,         32'h00000004);
    check("raw_ex_inst", ex_inst,         32'h00108133);
    check("raw_cnt3",    32'(stall_cnt),  32'd3);

    // lui x3,1 issued while write-back clears x3: set wins
    if_inst = 32'h000011B7; wb_rgf_we = 1'b1; wb_rgf_wa = 5'd3;
    #1 check("sc_if_rdy", 32'(if_rdy), 32'd1);
    tick();
    wb_rgf_we = 1'b0;
    check("sc_pend", sb_pend, 32'h0000000C);

    // sw x1,0(x0): no destination
    if_inst = 32'h00102023;
    #1 check("sw_if_rdy", 32'(if_rdy), 32'd1);
    tick();
    check("sw_pend",    sb_pend, 32'h0000000C);
    check("sw_ex_inst", ex_inst, 32'h00102023);

    // lui x3,2 while x3 pending: WAW stall
    if_inst = 32'h000021B7;
    #1 check("waw_hzd",  32'(hzd_stall), 32'd1);
    check("waw_if_rdy",  32'(if_rdy),    32'd0);
    tick();

    // addi x0,x0,0 never sets bit 0
    if_inst = 32'h00000013;
    #1 check("x0_if_rdy", 32'(if_rdy), 32'd1);
    tick();
    check("x0_pend",   sb_pend,        32'h0000000C);
    check("x0_ex_vld", 32'(ex_vld),    32'd1);
    check("x0_cnt",    32'(stall_cnt), 32'd4);

    // backpressure: slot full, execute not ready
    ex_rdy = 1'b0; if_inst = 32'h00100213;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_if_rdy",  32'(if_rdy),    32'd0);
      check("bp_hzd",     32'(hzd_stall), 32'd0);
      check("bp_ex_inst", ex_inst,        32'h00000013);
      check("bp_ex_vld",  32'(ex_vld),    32'd1);
      tick();
    end
    check("bp_cnt", 32'(stall_cnt), 32'd4);
    ex_rdy = 1'b1;
    #1 check("bp_rel_rdy", 32'(if_rdy), 32'd1);
    tick();
    check("bp_ex_inst2", ex_inst, 32'h00100213);
    check("bp_pend",     sb_pend, 32'h0000001C);

    // addi x5,x0,1 then flush
    if_inst = 32'h00100293;
    tick();
    check("fl_pre_pend",  sb_pend,     32'h0000003C);
    check("fl_pre_vld",   32'(ex_vld), 32'd1);
    flush = 1'b1; ex_rdy = 1'b0; if_inst = 32'h00100313;
    #1 check("fl_t_rdy", 32'(if_rdy),    32'd0);
    check("fl_t_hzd",    32'(hzd_stall), 32'd0);
    tick();
    flush = 1'b0; ex_rdy = 1'b1;
    check("fl_t1_vld", 32'(ex_vld), 32'd0);
    #1 check("fl_t1_rdy", 32'(if_rdy), 32'd0);
    tick();
    check("fl_t2_vld",  32'(ex_vld), 32'd0);
    check("fl_t2_pend", sb_pend,     32'h0000003C);
    #1 check("fl_t2_rdy", 32'(if_rdy), 32'd1);
    tick();
    check("fl_res_vld",  32'(ex_vld), 32'd1);
    check("fl_res_inst", ex_inst,     32'h00100313);
    check("fl_res_pend", sb_pend,     32'h0000007C);
    if_vld = 1'b0; wb_rgf_we = 1'b1; wb_rgf_wa = 5'd5;
    tick();
    wb_rgf_we = 1'b0;
    check("fl_wb_pend", sb_pend, 32'h0000005C);

    // asynchronous reset mid-operation
    #2 rst_n = 1'b0;
    #1;
    check("arst_pend", sb_pend,        32'd0);
    check("arst_vld",  32'(ex_vld),    32'd0);
    check("arst_cnt",  32'(stall_cnt), 32'd0);
    check("arst_inst", ex_inst,        32'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
